operand_entry_ctrl: RTL and testbench
=====================================

# operand_entry_ctrl

Front-panel operand entry controller for the DE10-Lite adder/subtractor datapath. Reads the four data switches, the operation switch, and two active-low push-buttons, debounces the buttons, and runs a three-state entry sequence that latches `a0`, then `a1` and `s`. The registered operands drive the adder/subtractor and its seven-segment displays.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable cycles required to accept a button level change (10 ms at 50 MHz).
- `CNT_W`, default 19: debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- `clk` in 1: system clock; one clock for the whole block.
- `rst_n` in 1: reset, synchronous, active-low.
- `sw` in 4: operand value switches; asynchronous.
- `sw_op` in 1: operation select (0 add, 1 subtract); asynchronous.
- `key_enter_n` in 1: enter button, active-low; asynchronous, bouncy.
- `key_clear_n` in 1: clear button, active-low; asynchronous, bouncy.
- `a0` out 4: first operand.
- `a1` out 4: second operand.
- `s` out 1: latched operation select.
- `state_led` out 3: one-hot state (bit0 ENTER_A, bit1 ENTER_B, bit2 SHOW).
- `valid` out 1: high while in SHOW; operands stable for the datapath.

## Operation
- Each button: 2-FF synchronizer, reset value 1 → debouncer → falling-edge detector.
- Debouncer: debounced level `db`, reset 1; counter reset 0. Synced input equal to `db` → counter clears to 0. Otherwise → counter increments; when the counter equals DEBOUNCE_CYCLES-1 and synced input still differs, `db` takes the synced value and the counter clears.
- Press pulse: one-cycle high when `db` goes 1→0 (registered). Release generates no pulse. Holding a button generates exactly one pulse.
- `sw` and `sw_op` pass through their own 2-FF synchronizers; captures use the synced values.
- FSM states: ENTER_A (reset state), ENTER_B, SHOW.
  - ENTER_A + enter pulse: `a0` ← synced `sw`; go to ENTER_B.
  - ENTER_B + enter pulse: `a1` ← synced `sw`, `s` ← synced `sw_op`; go to SHOW.
  - SHOW + enter pulse: go to ENTER_A; operands keep their values.
  - Any state + clear pulse: `a0`, `a1`, `s` ← 0; go to ENTER_A.
  - Enter and clear pulses in the same cycle: clear wins; the enter pulse is discarded.
- `valid` = (state == SHOW), registered with the state.
- Reset values: `a0`=0, `a1`=0, `s`=0, `state_led`=3'b001, `valid`=0. Reset asserted mid-debounce or mid-sequence aborts everything, including any pending pulse.

## Timing
- Switch synchronizer latency: 2 cycles.
- Button press-to-capture: key held low continuously from cycle 0 → synced low at cycle 2 → `db` falls at cycle 2+DEBOUNCE_CYCLES → pulse high the next cycle → operand and state update on the following edge. Total: DEBOUNCE_CYCLES+4 cycles.
- Bounce shorter than DEBOUNCE_CYCLES consecutive cycles: ignored; the counter restarts on every reversal.
- Operands change only on the capture edge, never combinationally from `sw`, unless the macro below is defined.

## Configuration
- `OPERAND_LIVE_PREVIEW_EN` defined:
  - In ENTER_A, the `a0` output shows synced `sw` live.
  - In ENTER_B, the `a1` output shows synced `sw` and the `s` output shows synced `sw_op` live.
  - The internal registers still capture only on enter.
- Not defined: outputs always show the registers.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4.
- Reset: hold `rst_n`=0 for 3 cycles → `a0`=0, `a1`=0, `s`=0, `state_led`=001, `valid`=0.
- Full sequence:
  - `sw`=5, press enter → `a0`=5, `state_led`=010.
  - `sw`=3, `sw_op`=1, press enter → `a1`=3, `s`=1, `valid`=1 exactly 8 cycles after the key goes low.
- Bounce rejection: toggle `key_enter_n` 0/1 every 2 cycles for 20 cycles, then hold at 1 → no pulse, state unchanged.
- Clear priority: in SHOW, debounced enter and clear pulses in the same cycle → `a0`=`a1`=0, `s`=0, state ENTER_A.
- Hold behaviour: in ENTER_A, hold enter low for 100 cycles → exactly one capture; state ENTER_B, not SHOW.
- Reset mid-debounce: assert reset at cycle 3 of a press, release it, keep the key low → capture only after a fresh DEBOUNCE_CYCLES+4 cycles.

Source files
------------

// File: rtl/operand_entry_ctrl.sv
// Front-panel operand entry: synchronizes switches and buttons, debounces the buttons and
// steps ENTER_A -> ENTER_B -> SHOW. Optional OPERAND_LIVE_PREVIEW_EN shows synced switches live.
module operand_entry_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 19
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] sw,
    input  logic       sw_op,
    input  logic       key_enter_n,
    input  logic       key_clear_n,
    output logic [3:0] a0,
    output logic [3:0] a1,
    output logic       s,
    output logic [2:0] state_led,
    output logic       valid
);

    localparam logic [1:0] ST_ENTER_A = 2'd0;
    localparam logic [1:0] ST_ENTER_B = 2'd1;
    localparam logic [1:0] ST_SHOW    = 2'd2;

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Button vectors: bit 0 is enter, bit 1 is clear.
    logic [1:0]            key_s1_q, key_s1_d;
    logic [1:0]            key_s2_q, key_s2_d;
    logic [1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]            db_q, db_d;
    logic [1:0]            db_prev_q, db_prev_d;
    logic [1:0]            press_q, press_d;

    // Switch vector: {sw_op, sw}.
    logic [4:0]            sw_s1_q, sw_s1_d;
    logic [4:0]            sw_s2_q, sw_s2_d;

    logic [1:0]            state_q, state_d;
    logic [3:0]            a0_q, a0_d;
    logic [3:0]            a1_q, a1_d;
    logic                  s_q, s_d;
    logic                  valid_q, valid_d;

    always_comb begin
        key_s1_d  = {key_clear_n, key_enter_n};
        key_s2_d  = key_s1_q;
        sw_s1_d   = {sw_op, sw};
        sw_s2_d   = sw_s1_q;
        db_d      = db_q;
        cnt_d     = '0;
        // The counter restarts whenever the synced level agrees with db again.
        for (int i = 0; i < 2; i++) begin
            if (key_s2_q[i] != db_q[i]) begin
                if (cnt_q[i] == DB_LAST) begin
                    db_d[i] = key_s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
        db_prev_d = db_q;
        press_d   = db_prev_q & ~db_q;
    end

    always_comb begin
        state_d = state_q;
        a0_d    = a0_q;
        a1_d    = a1_q;
        s_d     = s_q;
        // Clear dominates a simultaneous enter.
        if (press_q[1]) begin
            state_d = ST_ENTER_A;
            a0_d    = 4'd0;
            a1_d    = 4'd0;
            s_d     = 1'b0;
        end else if (press_q[0]) begin
            case (state_q)
                ST_ENTER_A: begin
                    a0_d    = sw_s2_q[3:0];
                    state_d = ST_ENTER_B;
                end
                ST_ENTER_B: begin
                    a1_d    = sw_s2_q[3:0];
                    s_d     = sw_s2_q[4];
                    state_d = ST_SHOW;
                end
                default: state_d = ST_ENTER_A;
            endcase
        end
        valid_d = (state_d == ST_SHOW);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            key_s1_q  <= 2'b11;
            key_s2_q  <= 2'b11;
            cnt_q     <= '0;
            db_q      <= 2'b11;
            db_prev_q <= 2'b11;
            press_q   <= 2'b00;
            sw_s1_q   <= 5'd0;
            sw_s2_q   <= 5'd0;
            state_q   <= ST_ENTER_A;
            a0_q      <= 4'd0;
            a1_q      <= 4'd0;
            s_q       <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            key_s1_q  <= key_s1_d;
            key_s2_q  <= key_s2_d;
            cnt_q     <= cnt_d;
            db_q      <= db_d;
            db_prev_q <= db_prev_d;
            press_q   <= press_d;
            sw_s1_q   <= sw_s1_d;
            sw_s2_q   <= sw_s2_d;
            state_q   <= state_d;
            a0_q      <= a0_d;
            a1_q      <= a1_d;
            s_q       <= s_d;
            valid_q   <= valid_d;
        end
    end

    always_comb begin
        case (state_q)
            ST_ENTER_B: state_led = 3'b010;
            ST_SHOW:    state_led = 3'b100;
            default:    state_led = 3'b001;
        endcase
    end

    assign valid = valid_q;

`ifdef OPERAND_LIVE_PREVIEW_EN
    assign a0 = (state_q == ST_ENTER_A) ? sw_s2_q[3:0] : a0_q;
    assign a1 = (state_q == ST_ENTER_B) ? sw_s2_q[3:0] : a1_q;
    assign s  = (state_q == ST_ENTER_B) ? sw_s2_q[4]   : s_q;
`else
    assign a0 = a0_q;
    assign a1 = a1_q;
    assign s  = s_q;
`endif

endmodule

// File: tb/tb_operand_entry_ctrl.sv
// Scoreboard bench for operand_entry_ctrl: a spec-level model predicts every visible output
// change and the cycle it must appear on; a monitor pops and compares on each change.
module tb_operand_entry_ctrl;

  localparam int DC  = 4;
  localparam int LAT = DC + 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] sw = 4'd0;
  logic       sw_op = 1'b0;
  logic       key_enter_n = 1'b1;
  logic       key_clear_n = 1'b1;
  logic [3:0] a0;
  logic [3:0] a1;
  logic       s;
  logic [2:0] state_led;
  logic       valid;

  operand_entry_ctrl #(.DEBOUNCE_CYCLES(DC), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .sw(sw), .sw_op(sw_op),
    .key_enter_n(key_enter_n), .key_clear_n(key_clear_n),
    .a0(a0), .a1(a1), .s(s), .state_led(state_led), .valid(valid)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  // scoreboard: expected snapshot {state_led, valid, s, a1, a0} and its cycle
  logic [12:0] exp_q[$];
  int          exp_cyc_q[$];

  // reference model: 0 = entering first operand, 1 = second, 2 = showing
  int         m_state = 0;
  logic [3:0] m_a0 = 4'd0;
  logic [3:0] m_a1 = 4'd0;
  logic       m_s = 1'b0;

  function automatic logic [12:0] model_out();
    logic [2:0] led;
    led = (m_state == 0) ? 3'b001 : (m_state == 1) ? 3'b010 : 3'b100;
    return {led, (m_state == 2), m_s, m_a1, m_a0};
  endfunction

  function automatic logic [12:0] dut_out();
    return {state_led, valid, s, a1, a0};
  endfunction

  task automatic push_if_changed(input logic [12:0] old, input int when);
    logic [12:0] nw;
    nw = model_out();
    if (nw !== old) begin
      exp_q.push_back(nw);
      exp_cyc_q.push_back(when);
    end
  endtask

  task automatic model_step(input bit en, input bit cl, input logic [3:0] v, input logic op,
                            input int when);
    logic [12:0] old;
    old = model_out();
    if (cl) begin
      m_state = 0; m_a0 = 4'd0; m_a1 = 4'd0; m_s = 1'b0;
    end else if (en) begin
      if (m_state == 0) begin
        m_a0 = v; m_state = 1;
      end else if (m_state == 1) begin
        m_a1 = v; m_s = op; m_state = 2;
      end else begin
        m_state = 0;
      end
    end
    push_if_changed(old, when);
  endtask

  task automatic model_reset(input int when);
    logic [12:0] old;
    old = model_out();
    m_state = 0; m_a0 = 4'd0; m_a1 = 4'd0; m_s = 1'b0;
    push_if_changed(old, when);
  endtask

  task automatic check_now(input string name);
    total++;
    if (dut_out() !== model_out()) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cyc %0d)", name, dut_out(), model_out(), cyc);
    end
  endtask

  task automatic check_drained(input string name);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s: %0d expected changes never seen, expected %0d", name, exp_q.size(), 0);
    end
  endtask

  // driver tasks
  task automatic press(input bit en, input bit cl, input int hold);
    int t0;
    @(negedge clk);
    t0 = cyc;
    if (en) key_enter_n = 1'b0;
    if (cl) key_clear_n = 1'b0;
    model_step(en, cl, sw, sw_op, t0 + LAT);
    repeat (hold) @(negedge clk);
    key_enter_n = 1'b1;
    key_clear_n = 1'b1;
    repeat (DC + 6) @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst_n = 1'b0;
    model_reset(cyc + 1);
    repeat (n) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic bounce_enter();
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      key_enter_n = 1'b0;
      repeat (2) @(negedge clk);
      key_enter_n = 1'b1;
      repeat (2) @(negedge clk);
    end
    repeat (DC + 8) @(negedge clk);
  endtask

  task automatic monitor();
    logic [12:0] prev;
    logic [12:0] cur;
    logic [12:0] e;
    int          ec;
    prev = dut_out();
    forever begin
      @(negedge clk);
      cur = dut_out();
      if (cur !== prev) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_change: got %h expected %h (cyc %0d)", cur, prev, cyc);
        end else begin
          e  = exp_q.pop_front();
          ec = exp_cyc_q.pop_front();
          if (cur !== e || cyc != ec) begin
            bad++;
            $display("FAIL output_change: got %h at cyc %0d expected %h at cyc %0d",
                     cur, cyc, e, ec);
          end
        end
      end
      prev = cur;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int t1;
    int act;

    // reset
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check_now("reset_values");
    fork
      monitor();
    join_none

    // full sequence
    sw = 4'd5; sw_op = 1'b0;
    press(1'b1, 1'b0, 10);
    check_now("capture_a0");
    sw = 4'd3; sw_op = 1'b1;
    press(1'b1, 1'b0, 10);
    check_now("capture_a1_show");

    // bounce rejection while showing
    sw = 4'd12;
    bounce_enter();
    check_now("bounce_ignored");
    check_drained("bounce_no_pulse");

    // clear wins over simultaneous enter
    press(1'b1, 1'b1, 10);
    check_now("clear_priority");

    // hold gives a single capture
    sw = 4'd9;
    press(1'b1, 1'b0, 100);
    check_now("hold_single_capture");

    // reset in the middle of a debounce
    @(negedge clk);
    t0 = cyc;
    sw = 4'd6;
    key_enter_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    model_reset(cyc + 1);
    @(negedge clk);
    rst_n = 1'b1;
    t1 = cyc;
    model_step(1'b1, 1'b0, sw, sw_op, t1 + LAT);
    repeat (12) @(negedge clk);
    key_enter_n = 1'b1;
    repeat (DC + 6) @(negedge clk);
    check_now("reset_mid_debounce");
    if (t0 < 0) $display("t0 %0d", t0);

    // randomized operation mix
    for (int it = 0; it < 40; it++) begin
      sw    = 4'($urandom_range(0, 15));
      sw_op = 1'($urandom_range(0, 1));
      repeat (3) @(negedge clk);
      act = $urandom_range(0, 9);
      if (act <= 4)      press(1'b1, 1'b0, $urandom_range(8, 20));
      else if (act == 5) press(1'b0, 1'b1, $urandom_range(8, 20));
      else if (act == 6) press(1'b1, 1'b1, $urandom_range(8, 20));
      else if (act == 7) bounce_enter();
      else if (act == 8) do_reset($urandom_range(1, 3));
      else               repeat ($urandom_range(1, 10)) @(negedge clk);
      check_now("random_step");
    end

    repeat (5) @(negedge clk);
    check_drained("final_queue_empty");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
